ltc5548_spi_responder: RTL

SPI responder (slave) for the LTC5548 system, the far end of the `spi_0` master link. It gives an external controller register access to the board: two writable control registers, plus read-only visibility of the latest ADC sample and the FFT max-index byte. All SPI pins are sampled on the system clock, so the block contains no SCLK-domain logic.

---
 rtl/ltc5548_spi_pkg.sv | 22 ++
 rtl/ltc5548_spi_responder_sync.sv | 30 +++
 rtl/ltc5548_spi_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ltc5548_spi_pkg.sv
// Shared constants and types for the LTC5548 SPI responder.
package ltc5548_spi_pkg;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_THRESH    = 3'd1;
  localparam logic [2:0] ADDR_ADC_LO    = 3'd2;
  localparam logic [2:0] ADDR_ADC_HI    = 3'd3;
  localparam logic [2:0] ADDR_MAX_INDEX = 3'd4;
  localparam logic [2:0] ADDR_FRAME_CNT = 3'd5;
  localparam logic [2:0] ADDR_RSVD      = 3'd6;
  localparam logic [2:0] ADDR_ID        = 3'd7;

  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ltc5548_spi_responder_sync.sv
// N-flop pin synchronizer with single-cycle rise/fall event pulses.
module spi_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Resetting to 0 means a fall can only follow a seen rise, so a frame
  // already in progress at reset release is never picked up mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/ltc5548_spi_responder.sv
// SPI mode-0 register responder, fully oversampled on the system clock.
module ltc5548_spi_responder
  import ltc5548_spi_pkg::*;
#(
  parameter logic [7:0]  ID_VALUE    = 8'hC5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_SCLK,
  input  logic        spi_MOSI,
  input  logic        spi_SS_n,
  output logic        spi_MISO,
  input  logic [11:0] adc_sample,
  input  logic [7:0]  max_index,
  output logic [7:0]  ctrl_reg,
  output logic [7:0]  thresh_reg,
  output logic        wr_strobe,
  output logic [2:0]  wr_addr,
  output logic        frame_err
);

  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_s;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [6:0]  shift_reg;
  logic [7:0]  tx_shift;
  logic        rw;
  logic [2:0]  addr;
  logic [11:0] adc_hold;
  logic [7:0]  frame_cnt;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  wr_data;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk_clk),
    .rst_n(reset_reset_n),
    .pin  (spi_SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk  (clk_clk),
    .rst_n(reset_reset_n),
    .pin  (spi_SS_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) mosi_chain <= '0;
    else                mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_MOSI};
  end

  assign mosi_s  = mosi_chain[SYNC_STAGES-1];
  assign wr_data = {shift_reg, mosi_s};

  // Address is decoded from the bit arriving on the 8th edge so the read
  // byte can be loaded in the same cycle as the command is latched.
  always_comb begin
    rd_addr = {shift_reg[1:0], mosi_s};
    rd_data = '0;
    case (rd_addr)
      ADDR_CTRL:      rd_data = ctrl_reg;
      ADDR_THRESH:    rd_data = thresh_reg;
      ADDR_ADC_LO:    rd_data = adc_hold[7:0];
      ADDR_ADC_HI:    rd_data = {4'h0, adc_hold[11:8]};
      ADDR_MAX_INDEX: rd_data = max_index;
      ADDR_FRAME_CNT: rd_data = frame_cnt;
      ADDR_RSVD:      rd_data = '0;
      ADDR_ID:        rd_data = ID_VALUE;
      default:        rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      tx_shift   <= '0;
      rw         <= 1'b0;
      addr       <= '0;
      adc_hold   <= '0;
      frame_cnt  <= '0;
      ctrl_reg   <= '0;
      thresh_reg <= '0;
      wr_addr    <= '0;
      wr_strobe  <= 1'b0;
      frame_err  <= 1'b0;
      spi_MISO   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (ss_rise) begin
        state    <= IDLE;
        spi_MISO <= 1'b0;
        if (state == CMD || state == DATA) frame_err <= 1'b1;
      end else if (ss_fall) begin
        state    <= CMD;
        bit_cnt  <= '0;
        adc_hold <= adc_sample;
        spi_MISO <= 1'b0;
      end else begin
        case (state)
          CMD: begin
            if (sclk_rise) begin
              shift_reg <= wr_data[6:0];
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rw    <= shift_reg[6];
                addr  <= rd_addr;
                tx_shift <= shift_reg[6] ? rd_data : 8'h00;
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shift_reg <= wr_data[6:0];
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                if (!rw && (addr == ADDR_CTRL || addr == ADDR_THRESH)) begin
                  if (addr == ADDR_CTRL) ctrl_reg <= wr_data;
                  else                   thresh_reg <= wr_data;
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                end
                frame_cnt <= frame_cnt + 8'd1;
                state     <= DONE;
              end
            end else if (sclk_fall && rw) begin
              spi_MISO <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
